// File: rtl/id_stage_pkg.sv
// Shared core types for the decode stage: op classes, RV32I opcodes and the
// packet handed from ID to EX.
package id_stage_pkg;

    typedef enum logic [3:0] {
        OP_ILLEGAL = 4'd0,
        OP_LUI     = 4'd1,
        OP_AUIPC   = 4'd2,
        OP_JAL     = 4'd3,
        OP_JALR    = 4'd4,
        OP_BRANCH  = 4'd5,
        OP_LOAD    = 4'd6,
        OP_STORE   = 4'd7,
        OP_IMM     = 4'd8,
        OP_REG     = 4'd9,
        OP_FENCE   = 4'd10,
        OP_SYSTEM  = 4'd11
    } op_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        op_e         op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        alt;
        logic [31:0] imm;
        logic        illegal;
    } id_pkt_t;

endpackage

// File: rtl/id_decoder.sv
// Combinational RV32I decoder: instruction word -> op class, register fields,
// sign-extended immediate and illegal flag. valid and pc are left at zero and
// filled in by the stage that owns the handshake.
module id_decoder
    import id_stage_pkg::*;
#(
    parameter bit SUPPORT_M = 1'b0
) (
    input  logic [31:0] instr,
    output id_pkt_t     pkt
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    op_e         op;
    logic [31:0] imm;

    assign opcode = instr[6:0];
    assign funct7 = instr[31:25];
    assign funct3 = instr[14:12];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // classify the opcode, rejecting reserved funct3/funct7 combinations
    always_comb begin
        op  = OP_ILLEGAL;
        imm = '0;
        if (instr[1:0] == 2'b11) begin
            case (opcode)
                OPC_LUI:    begin op = OP_LUI;    imm = imm_u; end
                OPC_AUIPC:  begin op = OP_AUIPC;  imm = imm_u; end
                OPC_JAL:    begin op = OP_JAL;    imm = imm_j; end
                OPC_JALR:   if (funct3 == 3'd0) begin op = OP_JALR; imm = imm_i; end
                OPC_BRANCH: if (funct3 != 3'd2 && funct3 != 3'd3) begin
                                op = OP_BRANCH; imm = imm_b;
                            end
                OPC_LOAD:   if (funct3 != 3'd3 && funct3 != 3'd6 && funct3 != 3'd7) begin
                                op = OP_LOAD; imm = imm_i;
                            end
                OPC_STORE:  if (funct3 <= 3'd2) begin op = OP_STORE; imm = imm_s; end
                OPC_OP_IMM: begin
                    // only the shift forms constrain funct7; SRAI alone may use the alt encoding
                    if ((funct3 != 3'd1 && funct3 != 3'd5) ||
                        (funct7 == F7_BASE) ||
                        (funct3 == 3'd5 && funct7 == F7_ALT)) begin
                        op = OP_IMM; imm = imm_i;
                    end
                end
                OPC_OP: begin
                    if ((funct7 == F7_BASE) ||
                        (funct7 == F7_ALT && (funct3 == 3'd0 || funct3 == 3'd5)) ||
                        (SUPPORT_M && funct7 == F7_MUL)) begin
                        op = OP_REG;
                    end
                end
                OPC_FENCE:  op = OP_FENCE;
                OPC_SYSTEM: begin op = OP_SYSTEM; imm = imm_i; end
                default:    op = OP_ILLEGAL;
            endcase
        end
    end

    // assemble the packet; rd is meaningless for classes that write no register
    always_comb begin
        pkt         = '0;
        pkt.op      = op;
        pkt.imm     = imm;
        pkt.illegal = (op == OP_ILLEGAL);
        pkt.rd      = (op == OP_BRANCH || op == OP_STORE || op == OP_FENCE) ? 5'd0 : instr[11:7];
        pkt.rs1     = instr[19:15];
        pkt.rs2     = instr[24:20];
        pkt.funct3  = funct3;
        pkt.alt     = instr[30];
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: takes one instruction per IF handshake, decodes it and holds
// the result in a single output slot offered to EX over valid/ack.
module id_stage
    import id_stage_pkg::*;
#(
    parameter bit SUPPORT_M = 1'b0
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        flush_i,
    input  logic        halt_i,
    input  logic        stall_i,
    input  logic        valid_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        ack_o,
    output logic        valid_o,
    input  logic        ack_i,
    output logic [31:0] pc_o,
    output logic [3:0]  op_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [2:0]  funct3_o,
    output logic        alt_o,
    output logic [31:0] imm_o,
    output logic        illegal_o
);

    id_pkt_t dec;
    id_pkt_t nxt;
    id_pkt_t pkt;
    logic    can_take;
    logic    take;

    id_decoder #(.SUPPORT_M(SUPPORT_M)) u_dec (
        .instr (instr_i),
        .pkt   (dec)
    );

    // the slot is free when empty or when EX drains it at this same edge
    assign can_take = !pkt.valid || ack_i;
    assign take     = valid_i && can_take && !stall_i && !flush_i && !halt_i;
    // held low through reset so IF never sees a handshake before we are live
    assign ack_o    = take && rstn_i;

    // decoded word tagged with its PC, ready to load into the slot
    always_comb begin
        nxt       = dec;
        nxt.valid = 1'b1;
        nxt.pc    = pc_i;
    end

    // output slot: halt freezes, flush drops, capture replaces, consume empties
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            pkt <= '0;
        end else if (!halt_i) begin
            if (flush_i)    pkt.valid <= 1'b0;
            else if (take)  pkt       <= nxt;
            else if (ack_i) pkt.valid <= 1'b0;
        end
    end

    assign valid_o   = pkt.valid;
    assign pc_o      = pkt.pc;
    assign op_o      = pkt.op;
    assign rd_o      = pkt.rd;
    assign rs1_o     = pkt.rs1;
    assign rs2_o     = pkt.rs2;
    assign funct3_o  = pkt.funct3;
    assign alt_o     = pkt.alt;
    assign imm_o     = pkt.imm;
    assign illegal_o = pkt.illegal;

endmodule
